// File: rtl/branch_predictor_pkg.sv
// ============================================================================
// Module      : branch_predictor_pkg
// Description : Shared branch-type encodings and 2-bit counter states.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package branch_predictor_pkg;

    typedef logic [2:0] br_type_t;
    typedef logic [1:0] ctr_t;

    localparam br_type_t NOBRANCH = 3'd0;
    localparam br_type_t BEQ      = 3'd1;
    localparam br_type_t BNE      = 3'd2;
    localparam br_type_t BLT      = 3'd3;
    localparam br_type_t BLTU     = 3'd4;
    localparam br_type_t BGE      = 3'd5;
    localparam br_type_t BGEU     = 3'd6;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
// ============================================================================
// Module      : sat_counter2
// Description : Next-state logic of a 2-bit saturating up/down counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
        end else begin
            if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit counters, fetch-side lookup,
//               EX-side training, misprediction flagging and perf counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      PCF,
    output logic             PredTakenF,
    output logic [31:0]      PredTargetF,
    input  logic [31:0]      PCE,
    input  logic [2:0]       BranchTypeE,
    input  logic             BranchE,
    input  logic [31:0]      BrTargetE,
    input  logic             PredTakenE,
    input  logic [31:0]      PredTargetE,
    input  logic             StallE,
    output logic             MispredictE,
    output logic [31:0]      CorrectPCE,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] MissCnt
);

    localparam int c_entries = 1 << IDX_W;
    localparam int c_tag_w   = 32 - IDX_W - 2;

    logic               r_valid  [c_entries];
    logic [c_tag_w-1:0] r_tag    [c_entries];
    logic [31:0]        r_target [c_entries];
    logic [1:0]         r_ctr    [c_entries];
    logic [CNT_W-1:0]   r_branch_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic [IDX_W-1:0]   w_f_idx;
    logic [c_tag_w-1:0] w_f_tag;
    logic               w_f_hit;
    logic [IDX_W-1:0]   w_e_idx;
    logic [c_tag_w-1:0] w_e_tag;
    logic               w_e_hit;
    logic               w_is_br;
    logic               w_upd;
    logic [1:0]         w_ctr_next;

    // Fetch lookup reads registered state only; updates appear after the edge.
    assign w_f_idx     = PCF[IDX_W+1:2];
    assign w_f_tag     = PCF[31:IDX_W+2];
    assign w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign PredTakenF  = w_f_hit && r_ctr[w_f_idx][1];
    assign PredTargetF = PredTakenF ? r_target[w_f_idx] : PCF + 32'd4;

    assign w_e_idx = PCE[IDX_W+1:2];
    assign w_e_tag = PCE[31:IDX_W+2];
    assign w_e_hit = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
    assign w_is_br = (BranchTypeE != NOBRANCH);
    assign w_upd   = w_is_br && !StallE && rst_n;

    assign MispredictE = w_is_br &&
                         ((BranchE != PredTakenE) ||
                          (BranchE && (PredTargetE != BrTargetE)));
    assign CorrectPCE  = (w_is_br && BranchE) ? BrTargetE : PCE + 32'd4;

    assign BranchCnt = r_branch_cnt;
    assign MissCnt   = r_miss_cnt;

    sat_counter2 u_sat_counter2 (
        .i_ctr   (r_ctr[w_e_idx]),
        .i_taken (BranchE),
        .o_ctr   (w_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_entries; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_WNT;
            end
        end else if (w_upd) begin
            if (w_e_hit) begin
                r_ctr[w_e_idx] <= w_ctr_next;
                if (BranchE) r_target[w_e_idx] <= BrTargetE;
            end else if (BranchE) begin
                // Taken miss evicts whatever lives at this index.
                r_valid[w_e_idx]  <= 1'b1;
                r_tag[w_e_idx]    <= w_e_tag;
                r_target[w_e_idx] <= BrTargetE;
                r_ctr[w_e_idx]    <= CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else if (w_upd) begin
            if (r_branch_cnt != {CNT_W{1'b1}}) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            if (MispredictE && (r_miss_cnt != {CNT_W{1'b1}})) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed plus randomized bench for branch_predictor.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int N = 64;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic [31:0] PCE;
    logic [2:0]  BranchTypeE;
    logic        BranchE;
    logic [31:0] BrTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        StallE;
    logic        MispredictE;
    logic [31:0] CorrectPCE;
    logic [31:0] BranchCnt;
    logic [31:0] MissCnt;

    branch_predictor #(.IDX_W(6), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .PCE         (PCE),
        .BranchTypeE (BranchTypeE),
        .BranchE     (BranchE),
        .BrTargetE   (BrTargetE),
        .PredTakenE  (PredTakenE),
        .PredTargetE (PredTargetE),
        .StallE      (StallE),
        .MispredictE (MispredictE),
        .CorrectPCE  (CorrectPCE),
        .BranchCnt   (BranchCnt),
        .MissCnt     (MissCnt)
    );

    always #5 clk = ~clk;

    // Reference model: one record per table slot, counter kept as 0..3.
    bit          m_valid  [N];
    bit [31:0]   m_tag    [N];
    bit [31:0]   m_target [N];
    int          m_ctr    [N];
    longint      m_bcnt;
    longint      m_mcnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void m_lookup(input bit [31:0] pc, output bit tk, output bit [31:0] tg);
        int idx;
        bit hit;
        idx = int'((pc >> 2) % N);
        hit = m_valid[idx] && (m_tag[idx] == (pc >> 8));
        tk  = hit && (m_ctr[idx] >= 2);
        tg  = tk ? m_target[idx] : pc + 32'd4;
    endfunction

    function automatic bit m_misp();
        if (BranchTypeE == NOBRANCH) return 1'b0;
        return (BranchE != PredTakenE) || (BranchE && (PredTargetE != BrTargetE));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_bcnt = 0;
            m_mcnt = 0;
        end else if (BranchTypeE != NOBRANCH && !StallE) begin
            int idx;
            bit hit;
            idx = int'((PCE >> 2) % N);
            hit = m_valid[idx] && (m_tag[idx] == (PCE >> 8));
            if (m_misp() && m_mcnt < CMAX) m_mcnt = m_mcnt + 1;
            if (m_bcnt < CMAX) m_bcnt = m_bcnt + 1;
            if (hit) begin
                if (BranchE) begin
                    m_ctr[idx]    = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                    m_target[idx] = BrTargetE;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                end
            end else if (BranchE) begin
                m_valid[idx]  = 1'b1;
                m_tag[idx]    = PCE >> 8;
                m_target[idx] = BrTargetE;
                m_ctr[idx]    = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit        tk;
            bit [31:0] tg;
            m_lookup(PCF, tk, tg);
            check("PredTakenF", {31'd0, PredTakenF}, {31'd0, tk});
            check("PredTargetF", PredTargetF, tg);
            check("MispredictE", {31'd0, MispredictE}, {31'd0, m_misp()});
            check("CorrectPCE", CorrectPCE,
                  (BranchTypeE != NOBRANCH && BranchE) ? BrTargetE : PCE + 32'd4);
            check("BranchCnt", BranchCnt, m_bcnt[31:0]);
            check("MissCnt", MissCnt, m_mcnt[31:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [2:0] t, input logic [31:0] pce, input logic tk,
                      input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                      input logic stall);
        BranchTypeE = t;
        PCE         = pce;
        BranchE     = tk;
        BrTargetE   = tgt;
        PredTakenE  = ptk;
        PredTargetE = ptgt;
        StallE      = stall;
    endtask

    task automatic idle();
        ex(NOBRANCH, 32'h0000_0040, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] rand_pc();
        int sel;
        sel = $urandom_range(0, 19);
        if (sel == 0) return 32'hFFFF_FFFC;
        if (sel == 1) return $urandom;
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        rst_n = 1'b0;
        PCF   = 32'h0000_0010;
        idle();
        tick();
        tick();
        chk_en = 1'b1;
        rst_n  = 1'b1;
        #2;
        check("rst PredTakenF", {31'd0, PredTakenF}, 32'd0);
        check("rst PredTargetF", PredTargetF, 32'h0000_0014);
        check("rst BranchCnt", BranchCnt, 32'd0);
        check("rst MissCnt", MissCnt, 32'd0);

        // Cold taken branch allocates with weak-taken.
        ex(BEQ, 32'h10, 1'b1, 32'h100, 1'b0, 32'h14, 1'b0);
        #2;
        check("cold MispredictE", {31'd0, MispredictE}, 32'd1);
        check("cold CorrectPCE", CorrectPCE, 32'h100);
        tick();
        idle();
        #2;
        check("cold PredTakenF", {31'd0, PredTakenF}, 32'd1);
        check("cold PredTargetF", PredTargetF, 32'h100);
        check("cold MissCnt", MissCnt, 32'd1);

        repeat (3) begin
            ex(BEQ, 32'h10, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
            tick();
        end
        ex(BEQ, 32'h10, 1'b0, 32'h100, 1'b1, 32'h100, 1'b0);
        #2;
        check("nt MispredictE", {31'd0, MispredictE}, 32'd1);
        check("nt CorrectPCE", CorrectPCE, 32'h14);
        tick();
        idle();
        #2;
        check("hyst PredTakenF", {31'd0, PredTakenF}, 32'd1);
        ex(BEQ, 32'h10, 1'b0, 32'h100, 1'b1, 32'h100, 1'b0);
        tick();
        idle();
        #2;
        check("2nt PredTakenF", {31'd0, PredTakenF}, 32'd0);
        check("2nt BranchCnt", BranchCnt, 32'd6);
        check("2nt MissCnt", MissCnt, 32'd3);

        // Aliasing: 0x110 shares the slot of 0x10 with a different tag.
        ex(BEQ, 32'h10, 1'b1, 32'h100, 1'b0, 32'h14, 1'b0);
        tick();
        ex(BEQ, 32'h110, 1'b1, 32'h200, 1'b0, 32'h114, 1'b0);
        tick();
        idle();
        #2;
        check("alias miss PredTargetF", PredTargetF, 32'h14);
        PCF = 32'h110;
        #2;
        check("alias hit PredTargetF", PredTargetF, 32'h200);

        ex(BNE, 32'h20, 1'b0, 32'h80, 1'b0, 32'h24, 1'b1);
        repeat (3) tick();
        #2;
        check("stall BranchCnt", BranchCnt, 32'd8);
        StallE = 1'b0;
        tick();
        idle();
        #2;
        check("release BranchCnt", BranchCnt, 32'd9);
        check("release MissCnt", MissCnt, 32'd5);

        ex(NOBRANCH, 32'h10, 1'b1, 32'h300, 1'b0, 32'h14, 1'b0);
        #2;
        check("nobr MispredictE", {31'd0, MispredictE}, 32'd0);
        check("nobr CorrectPCE", CorrectPCE, 32'h14);
        tick();
        idle();
        PCF = 32'h110;
        #2;
        check("nobr BranchCnt", BranchCnt, 32'd9);
        check("nobr PredTargetF", PredTargetF, 32'h200);

        PCF = 32'hFFFF_FFFC;
        #2;
        check("wrap PredTargetF", PredTargetF, 32'h0);

        rst_n = 1'b0;
        ex(BEQ, 32'h30, 1'b1, 32'h500, 1'b0, 32'h34, 1'b0);
        tick();
        rst_n = 1'b1;
        idle();
        PCF = 32'h30;
        #2;
        check("rstupd PredTakenF", {31'd0, PredTakenF}, 32'd0);
        check("rstupd PredTargetF", PredTargetF, 32'h34);
        check("rstupd BranchCnt", BranchCnt, 32'd0);
        check("rstupd MissCnt", MissCnt, 32'd0);

        for (int c = 0; c < 3000; c++) begin
            bit        tk;
            bit [31:0] tg;
            logic [31:0] pce;
            rst_n = ($urandom_range(0, 299) != 0);
            PCF   = rand_pc();
            pce   = rand_pc();
            m_lookup(pce, tk, tg);
            ex(($urandom_range(0, 3) == 0) ? NOBRANCH : 3'($urandom_range(1, 6)),
               pce, 1'($urandom),
               ($urandom_range(0, 1) == 0) ? 32'h100 + 32'($urandom_range(0, 3) << 4) : $urandom,
               1'b0, 32'h0, ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) != 0) begin
                PredTakenE  = tk;
                PredTargetE = tg;
            end else begin
                PredTakenE  = 1'($urandom);
                PredTargetE = ($urandom_range(0, 1) == 0) ? BrTargetE : $urandom;
            end
            tick();
        end

        #6;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage RV32I pipeline. Consumes the resolved branch outcome from the EX-stage branch decision unit (BranchE, BranchTypeE).
- Fetch side: combinational lookup on PCF supplies a predicted next PC.
- EX side: trains a direct-mapped BTB holding 2-bit saturating counters, flags mispredictions, supplies the corrected PC and keeps performance counters.

Parameters:
- IDX_W, 6, index bits; table holds 2^IDX_W entries.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- PCF  in  32  fetch-stage PC
- PredTakenF  out  1  predicted taken for PCF
- PredTargetF  out  32  predicted next PC for PCF
- PCE  in  32  PC of the instruction in EX
- BranchTypeE  in  3  branch type from the shared parameter file; NOBRANCH = not a branch
- BranchE  in  1  actual outcome from the branch decision unit
- BrTargetE  in  32  computed branch target (PCE+imm)
- PredTakenE  in  1  PredTakenF, piped to EX
- PredTargetE  in  32  PredTargetF, piped to EX
- StallE  in  1  EX stalled; suppresses update and counting
- MispredictE  out  1  flush request for IF/ID
- CorrectPCE  out  32  PC to redirect fetch to
- BranchCnt  out  CNT_W  resolved conditional branches
- MissCnt  out  CNT_W  mispredicted branches

Behaviour:
- Entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], ctr[1:0]. Index = PC[IDX_W+1:2]; PC[1:0] ignored.
- Reset (rst_n=0 at posedge):
  - all valid=0, ctr=2'b01, BranchCnt=MissCnt=0.
  - Reset is honoured in any cycle, including the same cycle as an update; reset wins.
- Lookup is combinational on registered table state:
  - hit = valid && tag match.
  - PredTakenF = hit && ctr[1].
  - PredTargetF = PredTakenF ? target : PCF+4, with wrap-around modulo 2^32.
  - No write-to-read bypass: an update at edge N becomes visible to lookups after edge N.
- Update strobe: upd = (BranchTypeE != NOBRANCH) && !StallE && rst_n. Table state changes at posedge only when upd=1.
- Update on hit at the PCE index:
  - BranchE=1: ctr saturating increment, 11 stays 11; target <= BrTargetE.
  - BranchE=0: ctr saturating decrement, 00 stays 00; target unchanged.
- Update on miss:
  - BranchE=1: allocate, overwriting any valid entry with a different tag. valid=1, tag, target=BrTargetE, ctr=2'b10.
  - BranchE=0: no allocation; table unchanged.
- Counter FSM per entry: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Taken moves up one state and not-taken moves down one, both saturating.
- MispredictE and CorrectPCE are combinational, gated by (BranchTypeE != NOBRANCH), and independent of StallE:
  - MispredictE = (BranchE != PredTakenE) || (BranchE && PredTargetE != BrTargetE).
  - CorrectPCE = BranchE ? BrTargetE : PCE+4.
  - For non-branches, MispredictE=0 and CorrectPCE=PCE+4.
- Performance counters, updated when upd=1:
  - BranchCnt += 1.
  - MissCnt += MispredictE.
  - Both saturate at all-ones; they do not wrap.
- A stalled EX instruction (StallE=1 for k cycles) is counted and trained exactly once, in the cycle StallE=0.

Decomposition:
- Shared parameter include: branch type encodings (NOBRANCH, BEQ, BNE, BLT, BLTU, BGE, BGEU) and the counter state constants CTR_SNT/WNT/WT/ST. No new constants are local to the block.
- One natural sub-module: sat_counter2, the 2-bit saturating up/down next-state logic. It is instanced per update path, not per entry.
- The table is flat register arrays with a synchronous-reset loop.

Test Plan:
- Reset then lookup: rst_n=0 for 2 cycles, then PCF=0x00000010 -> PredTakenF=0, PredTargetF=0x00000014, BranchCnt=MissCnt=0.
- Cold taken branch: PCE=0x00000010, BEQ, BranchE=1, BrTargetE=0x00000100, PredTakenE=0 -> MispredictE=1, CorrectPCE=0x00000100. Next cycle, PCF=0x00000010 gives PredTakenF=1, PredTargetF=0x00000100. MissCnt=1.
- Saturation and hysteresis on the same entry:
  - 3 further taken updates -> ctr=11.
  - One not-taken -> still predicts taken (ctr=10).
  - Second not-taken -> PredTakenF=0.
  - Not-taken with PredTakenE=1 -> MispredictE=1, CorrectPCE=PCE+4.
- Aliasing: train PCE=0x00000010 taken, then PCE=0x00000110 (same index, different tag) taken to 0x00000200. Lookup of 0x00000010 misses (PredTargetF=0x00000014); lookup of 0x00000110 hits with 0x00000200.
- Stall and non-branch gating:
  - BNE held with StallE=1 for 3 cycles, then released -> BranchCnt increments by exactly 1.
  - BranchTypeE=NOBRANCH with BranchE=1 forced -> MispredictE=0, no table or counter change.
- Wrap and reset mid-operation:
  - PCF=0xFFFFFFFC on a miss -> PredTargetF=0x00000000.
  - rst_n=0 in the same cycle as a valid update -> entry not allocated, counters 0.
